// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-master to single memory port arbiter with in-order response routing
//
// Optional feature macro: MEM_ARB_BURST_EN
//   defined   : on a tie the last-granted master keeps the port for up to BURST_MAX beats
//   undefined : on a tie the master that did not win last time is granted (strict alternation)
//
// Ports
//   clk, rst                      : single clock, synchronous active-high reset
//   m0_*/m1_* req,addr,we,be,wdata: master request channel, held until gnt
//   m0_*/m1_* gnt                 : beat accepted by memory for that master
//   m0_*/m1_* rvalid,err,rdata    : response routed back to the owning master
//   mem_req,addr,we,be,wdata      : request to memory (muxed from the winner)
//   mem_gnt                       : memory accepts the current beat
//   mem_rvalid,err,rdata          : memory response, in acceptance order
module mem_port_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int BURST_MAX  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    m0_req,
    input  logic [ADDR_WIDTH-1:0]   m0_addr,
    input  logic                    m0_we,
    input  logic [DATA_WIDTH/8-1:0] m0_be,
    input  logic [DATA_WIDTH-1:0]   m0_wdata,
    output logic                    m0_gnt,
    output logic                    m0_rvalid,
    output logic                    m0_err,
    output logic [DATA_WIDTH-1:0]   m0_rdata,
    input  logic                    m1_req,
    input  logic [ADDR_WIDTH-1:0]   m1_addr,
    input  logic                    m1_we,
    input  logic [DATA_WIDTH/8-1:0] m1_be,
    input  logic [DATA_WIDTH-1:0]   m1_wdata,
    output logic                    m1_gnt,
    output logic                    m1_rvalid,
    output logic                    m1_err,
    output logic [DATA_WIDTH-1:0]   m1_rdata,
    output logic                    mem_req,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic                    mem_we,
    output logic [DATA_WIDTH/8-1:0] mem_be,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic                    mem_gnt,
    input  logic                    mem_rvalid,
    input  logic                    mem_err,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    if (DATA_WIDTH % 8 != 0) begin : g_bad_data_width
        $error("DATA_WIDTH must be a multiple of 8");
    end
    if (BURST_MAX < 1 || BURST_MAX > 15) begin : g_bad_burst_max
        $error("BURST_MAX must be in 1..15");
    end

    // Owner FIFO: two entries of master id, one per outstanding beat.
    logic [1:0] owner_q;
    logic       wr_ptr_q, rd_ptr_q;
    logic [1:0] count_q, count_d;
    logic       last_q;

    logic any_req, tie_win, win, head, fifo_empty, fifo_full;
    logic pop, push, stall, resp_ok;

    assign any_req    = m0_req | m1_req;
    assign fifo_empty = (count_q == 2'd0);
    assign fifo_full  = (count_q == 2'd2);
    assign head       = owner_q[rd_ptr_q];

    // A pop frees a slot in the same cycle, so a full FIFO only stalls without one.
    assign pop     = mem_rvalid & ~fifo_empty & ~rst;
    assign stall   = fifo_full & ~pop;
    assign mem_req = any_req & ~stall & ~rst;
    assign push    = mem_req & mem_gnt;

`ifdef MEM_ARB_BURST_EN
    localparam logic [3:0] BURST_MAX_C = 4'(BURST_MAX);
    logic [3:0] cnt_q, cnt_d;

    // cnt_q == 0 means no burst owner yet (fresh from reset), so the tie goes to
    // the master opposite last_q, which makes master 0 win the first tie.
    assign tie_win = (cnt_q != 4'd0 && cnt_q < BURST_MAX_C) ? last_q : ~last_q;

    always_comb begin
        cnt_d = cnt_q;
        if (push) begin
            if (win != last_q) begin
                cnt_d = 4'd1;
            end else if (cnt_q < BURST_MAX_C) begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign tie_win = ~last_q;
`endif

    // With a single requester m1_req alone decides; with none the value is irrelevant.
    assign win = (m0_req & m1_req) ? tie_win : m1_req;

    assign mem_addr  = any_req ? (win ? m1_addr  : m0_addr)  : '0;
    assign mem_we    = any_req ? (win ? m1_we    : m0_we)    : 1'b0;
    assign mem_be    = any_req ? (win ? m1_be    : m0_be)    : '0;
    assign mem_wdata = any_req ? (win ? m1_wdata : m0_wdata) : '0;

    assign m0_gnt = push & ~win;
    assign m1_gnt = push &  win;

    assign resp_ok   = ~rst & ~fifo_empty;
    assign m0_rvalid = resp_ok & mem_rvalid & ~head;
    assign m1_rvalid = resp_ok & mem_rvalid &  head;
    assign m0_err    = resp_ok & mem_rvalid & mem_err & ~head;
    assign m1_err    = resp_ok & mem_rvalid & mem_err &  head;
    assign m0_rdata  = (resp_ok & ~head) ? mem_rdata : '0;
    assign m1_rdata  = (resp_ok &  head) ? mem_rdata : '0;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q  <= 2'b00;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            last_q   <= 1'b1;
        end else begin
            count_q <= count_d;
            if (push) begin
                owner_q[wr_ptr_q] <= win;
                wr_ptr_q          <= ~wr_ptr_q;
                last_q            <= win;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    localparam int DW   = 32;
    localparam int AW   = 32;
    localparam int BW   = DW / 8;
    localparam int BMAX = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          req_v[2];
    logic [AW-1:0] addr_v[2];
    logic          we_v[2];
    logic [BW-1:0] be_v[2];
    logic [DW-1:0] wd_v[2];
    logic          gnt_o[2];
    logic          rv_o[2];
    logic          err_o[2];
    logic [DW-1:0] rdata_o[2];

    logic          mem_req, mem_we, mem_gnt, mem_rvalid, mem_err;
    logic [AW-1:0] mem_addr;
    logic [BW-1:0] mem_be;
    logic [DW-1:0] mem_wdata, mem_rdata;

    mem_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_MAX(BMAX)) dut (
        .clk(clk), .rst(rst),
        .m0_req(req_v[0]), .m0_addr(addr_v[0]), .m0_we(we_v[0]), .m0_be(be_v[0]),
        .m0_wdata(wd_v[0]), .m0_gnt(gnt_o[0]), .m0_rvalid(rv_o[0]), .m0_err(err_o[0]),
        .m0_rdata(rdata_o[0]),
        .m1_req(req_v[1]), .m1_addr(addr_v[1]), .m1_we(we_v[1]), .m1_be(be_v[1]),
        .m1_wdata(wd_v[1]), .m1_gnt(gnt_o[1]), .m1_rvalid(rv_o[1]), .m1_err(err_o[1]),
        .m1_rdata(rdata_o[1]),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_err(mem_err), .mem_rdata(mem_rdata)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: outstanding owners in order, last winner, burst length.
    int owners[$];
    int last_m = 1;
    int cnt_m  = 0;

    // Observations from the latest step, for directed checks.
    logic          obs_gnt[2];
    logic          obs_rv[2];
    logic          obs_err[2];
    logic [DW-1:0] obs_rdata[2];
    logic [BW-1:0] obs_be;
    int            obs_win;
    bit            exp_gnt[2];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input bit r0, input bit r1);
        if (r0 && !r1) return 0;
        if (r1 && !r0) return 1;
        if (!r0) return 0;
`ifdef MEM_ARB_BURST_EN
        if (cnt_m >= 1 && cnt_m < BMAX) return last_m;
`endif
        return 1 - last_m;
    endfunction

    // Inputs are already applied; check combinational outputs, then advance one edge.
    task automatic step();
        int win, sz, head;
        bit anyr, pop, stall, mreq, acc;
        #1;
        sz    = owners.size();
        head  = (sz > 0) ? owners[0] : -1;
        anyr  = req_v[0] || req_v[1];
        win   = pick(req_v[0], req_v[1]);
        pop   = !rst && mem_rvalid && sz > 0;
        stall = (sz == 2) && !pop;
        mreq  = !rst && anyr && !stall;
        acc   = mreq && mem_gnt;
        check("mem_req", 64'(mem_req), 64'(mreq));
        if (!rst) begin
            check("mem_addr",  64'(mem_addr),  anyr ? 64'(addr_v[win]) : 64'd0);
            check("mem_we",    64'(mem_we),    anyr ? 64'(we_v[win])   : 64'd0);
            check("mem_be",    64'(mem_be),    anyr ? 64'(be_v[win])   : 64'd0);
            check("mem_wdata", 64'(mem_wdata), anyr ? 64'(wd_v[win])   : 64'd0);
        end
        for (int x = 0; x < 2; x++) begin
            bit own;
            own        = !rst && head == x;
            exp_gnt[x] = acc && win == x;
            check($sformatf("m%0d_gnt", x),    64'(gnt_o[x]),   64'(exp_gnt[x]));
            check($sformatf("m%0d_rvalid", x), 64'(rv_o[x]),    64'(own && mem_rvalid));
            check($sformatf("m%0d_err", x),    64'(err_o[x]),   64'(own && mem_rvalid && mem_err));
            check($sformatf("m%0d_rdata", x),  64'(rdata_o[x]), own ? 64'(mem_rdata) : 64'd0);
            obs_gnt[x]   = gnt_o[x];
            obs_rv[x]    = rv_o[x];
            obs_err[x]   = err_o[x];
            obs_rdata[x] = rdata_o[x];
        end
        obs_be  = mem_be;
        obs_win = gnt_o[0] ? 0 : (gnt_o[1] ? 1 : -1);
        @(posedge clk);
        if (rst) begin
            owners.delete();
            last_m = 1;
            cnt_m  = 0;
        end else begin
            if (pop) void'(owners.pop_front());
            if (acc) begin
                owners.push_back(win);
                if (win == last_m) cnt_m = (cnt_m < BMAX) ? cnt_m + 1 : cnt_m;
                else cnt_m = 1;
                last_m = win;
            end
        end
        #1;
    endtask

    task automatic new_beat(input int x, input bit on);
        req_v[x]  = on;
        addr_v[x] = $urandom;
        we_v[x]   = 1'($urandom % 2);
        be_v[x]   = BW'($urandom);
        wd_v[x]   = $urandom;
    endtask

    initial begin
        int w0, w1, exp_w;
        rst = 1'b1;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_err = 1'b0; mem_rdata = '0;
        for (int x = 0; x < 2; x++) new_beat(x, 1'b0);

        // Reset: everything quiet, even with requests pending.
        step();
        req_v[0] = 1'b1; req_v[1] = 1'b1; mem_gnt = 1'b1; mem_rvalid = 1'b1;
        step();
        check("rst_gnt", 64'(obs_gnt[0] | obs_gnt[1]), 64'd0);
        req_v[0] = 1'b0; req_v[1] = 1'b0; mem_rvalid = 1'b0;
        rst = 1'b0;

        // Single read from m0.
        req_v[0] = 1'b1; addr_v[0] = 32'h10; we_v[0] = 1'b0; be_v[0] = '1;
        step();
        check("rd_m0_gnt", 64'(obs_gnt[0]), 64'd1);
        req_v[0] = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hA5A5_A5A5;
        step();
        check("rd_m0_rvalid", 64'(obs_rv[0]), 64'd1);
        check("rd_m0_rdata", 64'(obs_rdata[0]), 64'hA5A5_A5A5);
        check("rd_m1_rvalid", 64'(obs_rv[1]), 64'd0);
        mem_rvalid = 1'b0;

        // Continuous contention from reset: grant order.
        rst = 1'b1;
        step();
        rst = 1'b0;
        new_beat(0, 1'b1); new_beat(1, 1'b1);
        mem_gnt = 1'b1; mem_rvalid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
`ifdef MEM_ARB_BURST_EN
            exp_w = (i / BMAX) % 2;
`else
            exp_w = i % 2;
`endif
            check($sformatf("order_%0d", i), 64'(obs_win), 64'(exp_w));
        end
        req_v[0] = 1'b0; req_v[1] = 1'b0;
        step();
        mem_rvalid = 1'b0;

        // m1 write with partial byte enables and an error response.
        req_v[1] = 1'b1; addr_v[1] = 32'h20; we_v[1] = 1'b1; be_v[1] = 4'b0011; wd_v[1] = 32'h1234;
        step();
        check("wr_mem_be", 64'(obs_be), 64'h3);
        check("wr_m1_gnt", 64'(obs_gnt[1]), 64'd1);
        req_v[1] = 1'b0; mem_rvalid = 1'b1; mem_err = 1'b1;
        step();
        check("wr_m1_err", 64'(obs_err[1]), 64'd1);
        check("wr_m1_rvalid", 64'(obs_rv[1]), 64'd1);
        check("wr_m0_err", 64'(obs_err[0]), 64'd0);
        mem_rvalid = 1'b0; mem_err = 1'b0;

        // Withheld responses: two beats fill the FIFO, then grants stop.
        new_beat(0, 1'b1); new_beat(1, 1'b1);
        step();
        w0 = obs_win;
        check("full_beat0", 64'(obs_gnt[0] | obs_gnt[1]), 64'd1);
        step();
        w1 = obs_win;
        check("full_beat1", 64'(obs_gnt[0] | obs_gnt[1]), 64'd1);
        step();
        check("full_stall", 64'(obs_gnt[0] | obs_gnt[1]), 64'd0);
        req_v[0] = 1'b0; req_v[1] = 1'b0; mem_rvalid = 1'b1;
        step();
        check("full_resp0", 64'(obs_rv[w0 & 1]), 64'(w0 >= 0));
        step();
        check("full_resp1", 64'(obs_rv[w1 & 1]), 64'(w1 >= 0));
        mem_rvalid = 1'b0;

        // Reset with an m0 beat outstanding.
        new_beat(0, 1'b1);
        step();
        check("rst_fly_gnt", 64'(obs_gnt[0]), 64'd1);
        req_v[0] = 1'b0; rst = 1'b1; mem_rvalid = 1'b1;
        step();
        check("rst_fly_rv_in", 64'(obs_rv[0]), 64'd0);
        rst = 1'b0;
        new_beat(0, 1'b1); new_beat(1, 1'b1);
        step();
        check("rst_fly_rv_after", 64'(obs_rv[0]), 64'd0);
        check("rst_fly_tie", 64'(obs_win), 64'd0);
        req_v[0] = 1'b0; req_v[1] = 1'b0;
        step();
        mem_rvalid = 1'b0;

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            mem_gnt    = ($urandom % 4) != 0;
            mem_rvalid = ($urandom % 3) != 0;
            mem_err    = ($urandom % 5) == 0;
            mem_rdata  = $urandom;
            rst        = ($urandom % 250) == 0;
            step();
            for (int x = 0; x < 2; x++) begin
                if (exp_gnt[x] || !req_v[x]) new_beat(x, ($urandom % 4) != 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
